sm_tdm_send_mc: RTL and testbench
=================================

# sm_tdm_send_mc

Multi-channel successor of the surveillance module's TDM send monitor. It watches `NUM_CHANNELS` independent TDM flit streams and tracks packet boundaries per channel from the size header. For every well-formed header it emits one event carrying channel, destination endpoint and length. Events pass through a round-robin arbiter into a shared event FIFO with a valid/ready output, which feeds the surveillance module's event logic.

## Interface
- `NUM_CHANNELS`, 4: monitored TDM streams (≥1).
- `MAX_LEN`, 8: largest legal payload length in flits (≥1); `LW = $clog2(MAX_LEN+1)`.
- `NUM_TDM_ENDPOINTS`, 4: endpoint count; `EW = $clog2(NUM_TDM_ENDPOINTS)`, minimum 1.
- `FIFO_DEPTH`, 4: event FIFO entries (power of two, ≥2); `CW = $clog2(NUM_CHANNELS)`, minimum 1.
- `clk` in 1: sole clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `enable` in NUM_CHANNELS: per-channel flit strobe.
- `data` in 32*NUM_CHANNELS: channel c flit is `data[32c+:32]`.
- `ep` in EW*NUM_CHANNELS: channel c destination endpoint, sampled on that channel's header.
- `evt_valid` out 1: FIFO head is valid.
- `evt_ready` in 1: consumer accepts the head.
- `evt_chan` out CW: channel of the head event.
- `evt_dest` out EW: destination of the head event.
- `evt_len` out LW: payload length of the head event.
- `err_len` out NUM_CHANNELS: sticky flag, illegal size header seen.
- `err_drop` out NUM_CHANNELS: sticky flag, event lost because the pending slot was full.
- `err_clr` in 1: clears all sticky flags.

## Operation
- Per-channel FSM with states SIZE and DRAIN, plus a remaining-count register `rem[LW-1:0]`.
- A flit counts only when it arrives with `enable[c]`=1.
- **SIZE:**
  - `s = data[32c+:LW]`.
  - If `1 ≤ s ≤ MAX_LEN`: load `rem=s`, go to DRAIN, raise the header event.
  - Otherwise (0, or above MAX_LEN): set `err_len[c]`, stay in SIZE, no event.
  - Bits above LW are ignored.
- **DRAIN:** each flit decrements `rem`. On the flit with `rem==1`, return to SIZE. `rem` never wraps.
- **Pending slot (one per channel):** a header event writes `{ep[c], s}` into the slot. If the slot is already full and is not being granted in that same cycle, the new event is discarded and `err_drop[c]` is set. The FSM still advances normally.
- **Arbiter:** round-robin over the full pending slots. At most one grant per cycle, and only when the FIFO is not full. The pointer moves to the granted channel +1, wrapping to 0 after `NUM_CHANNELS-1`.
- **FIFO:** ordinary synchronous FIFO.
  - Push = grant; pop = `evt_valid & evt_ready`.
  - Push and pop in the same cycle are allowed when it is full; the occupancy stays the same.
  - Pop when empty is ignored.
- **`err_clr`:** clears the flags. A set event in the same cycle wins over the clear.
- **Reset:** asynchronous assertion at any point, including mid-packet.
  - All FSMs return to SIZE, `rem=0`.
  - Slots and FIFO are emptied and the arbiter pointer is 0.
  - `evt_valid=0`, `evt_chan/evt_dest/evt_len=0`, `err_len=0`, `err_drop=0`.
  - A packet interrupted by reset is forgotten: the next flit is treated as a header.

## Timing
- Header accepted in cycle t → slot full from t+1 → granted in t+1 if it wins arbitration and the FIFO is not full → `evt_valid` in t+2 if the FIFO was empty.
- Minimum latency is 2 cycles. Each competing channel ahead in the round-robin order adds 1 cycle.
- A slot granted in cycle t can accept a new header in the same cycle t.
- Error flags are set in the cycle after the offending flit.
- Event outputs are driven from registers; there is no combinational path from `enable`/`data` to the outputs.
- Throughput is one event per cycle into and out of the FIFO.

## Configuration
- Macro: `SM_TDM_SEND_MC_STATS_EN`.
- Defined: adds output `pkt_cnt` (16*NUM_CHANNELS).
  - One counter per channel, incremented on each accepted legal header, including headers whose event is dropped.
  - Saturates at 0xFFFF, is cleared by `err_clr`, and resets to 0.
- Undefined: the port and the counters do not exist. All other behaviour is identical.

## Test plan
- Channel 0, header 3 with ep=2, then 3 payload flits, `evt_ready`=1 → one event {chan 0, dest 2, len 3} with `evt_valid` high exactly in cycle t+2. The next flit is taken as a header.
- Headers on all 4 channels in the same cycle, `evt_ready`=1 → events appear in order chan 0,1,2,3 in consecutive cycles t+2..t+5.
- Header size 0, then header size 9 (MAX_LEN=8) on channel 1 → no events, `err_len[1]`=1. A following legal header 2 produces an event; `err_clr` returns the flag to 0.
- `evt_ready`=0, channel 2 sends 6 single-flit packets back to back → 4 events in FIFO, 1 in the slot, `err_drop[2]`=1. Raising ready drains 5 events with len 1.
- `rst_n` low in the middle of a len-5 packet on channel 3 → all outputs 0 immediately. After release, a flit carrying 4 is a header and produces event len 4.
- `SM_TDM_SEND_MC_STATS_EN` defined: 3 legal headers and 1 illegal header on channel 0 → `pkt_cnt[15:0]`=3. Forcing 0xFFFF and sending a further legal header → stays 0xFFFF.

Source files
------------

// File: rtl/sm_tdm_send_mc.sv
// Multi-channel TDM send monitor: per-channel size-header tracking, pending event slots,
// a round-robin arbiter and a shared event FIFO. Optional SM_TDM_SEND_MC_STATS_EN adds pkt_cnt.
module sm_tdm_send_mc #(
  parameter int NUM_CHANNELS      = 4,
  parameter int MAX_LEN           = 8,
  parameter int NUM_TDM_ENDPOINTS = 4,
  parameter int FIFO_DEPTH        = 4,
  localparam int LW = $clog2(MAX_LEN + 1),
  localparam int EW = (NUM_TDM_ENDPOINTS > 1) ? $clog2(NUM_TDM_ENDPOINTS) : 1,
  localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CHANNELS-1:0]    enable,
  input  logic [32*NUM_CHANNELS-1:0] data,
  input  logic [EW*NUM_CHANNELS-1:0] ep,
  output logic                       evt_valid,
  input  logic                       evt_ready,
  output logic [CW-1:0]              evt_chan,
  output logic [EW-1:0]              evt_dest,
  output logic [LW-1:0]              evt_len,
  output logic [NUM_CHANNELS-1:0]    err_len,
  output logic [NUM_CHANNELS-1:0]    err_drop,
  input  logic                       err_clr
`ifdef SM_TDM_SEND_MC_STATS_EN
  ,
  output logic [16*NUM_CHANNELS-1:0] pkt_cnt
`endif
);

  localparam int unsigned NC = NUM_CHANNELS;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic {ST_SIZE, ST_DRAIN} state_e;

  state_e        state_q [NUM_CHANNELS];
  state_e        state_d [NUM_CHANNELS];
  logic [LW-1:0] rem_q   [NUM_CHANNELS];
  logic [LW-1:0] rem_d   [NUM_CHANNELS];
  logic [LW-1:0] size_w  [NUM_CHANNELS];

  logic [NUM_CHANNELS-1:0] hdr_ok;
  logic [NUM_CHANNELS-1:0] hdr_bad;
  logic [NUM_CHANNELS-1:0] drop_set;

  logic [NUM_CHANNELS-1:0] slot_full_q;
  logic [EW-1:0]           slot_ep_q  [NUM_CHANNELS];
  logic [LW-1:0]           slot_len_q [NUM_CHANNELS];

  logic [CW-1:0]           rr_ptr_q;
  logic [CW-1:0]           gnt_idx;
  logic [CW-1:0]           rr_cand;
  int unsigned             rr_idx;
  logic                    gnt_any;
  logic [NUM_CHANNELS-1:0] gnt;

  logic [CW-1:0] fifo_chan [FIFO_DEPTH];
  logic [EW-1:0] fifo_dest [FIFO_DEPTH];
  logic [LW-1:0] fifo_len  [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          fifo_full;
  logic          fifo_room;
  logic          push;
  logic          pop;

  logic [NUM_CHANNELS-1:0] err_len_q;
  logic [NUM_CHANNELS-1:0] err_drop_q;

  // Per-channel header/drain FSM.
  always_comb begin
    hdr_ok  = '0;
    hdr_bad = '0;
    for (int unsigned c = 0; c < NC; c++) begin
      size_w[c]  = data[32*c +: LW];
      state_d[c] = state_q[c];
      rem_d[c]   = rem_q[c];
      if (enable[c]) begin
        case (state_q[c])
          ST_SIZE: begin
            if (size_w[c] != '0 && size_w[c] <= LW'(MAX_LEN)) begin
              hdr_ok[c]  = 1'b1;
              rem_d[c]   = size_w[c];
              state_d[c] = ST_DRAIN;
            end else begin
              hdr_bad[c] = 1'b1;
            end
          end
          ST_DRAIN: begin
            if (rem_q[c] <= LW'(1)) begin
              rem_d[c]   = '0;
              state_d[c] = ST_SIZE;
            end else begin
              rem_d[c] = rem_q[c] - LW'(1);
            end
          end
          default: state_d[c] = ST_SIZE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < NC; c++) begin
        state_q[c] <= ST_SIZE;
        rem_q[c]   <= '0;
      end
    end else begin
      for (int unsigned c = 0; c < NC; c++) begin
        state_q[c] <= state_d[c];
        rem_q[c]   <= rem_d[c];
      end
    end
  end

  // Round-robin search starting at rr_ptr_q over the occupied slots.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    gnt     = '0;
    rr_idx  = 0;
    rr_cand = '0;
    if (fifo_room) begin
      for (int unsigned i = 0; i < NC; i++) begin
        rr_idx = 32'(rr_ptr_q) + i;
        if (rr_idx >= NC) rr_idx = rr_idx - NC;
        rr_cand = CW'(rr_idx);
        if (!gnt_any && slot_full_q[rr_cand]) begin
          gnt_any = 1'b1;
          gnt_idx = rr_cand;
        end
      end
    end
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end

  always_comb begin
    drop_set = '0;
    for (int unsigned c = 0; c < NC; c++) begin
      drop_set[c] = hdr_ok[c] && slot_full_q[c] && !gnt[c];
    end
  end

  // A slot being granted this cycle is free to take a new header in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_full_q <= '0;
      rr_ptr_q    <= '0;
      for (int unsigned c = 0; c < NC; c++) begin
        slot_ep_q[c]  <= '0;
        slot_len_q[c] <= '0;
      end
    end else begin
      for (int unsigned c = 0; c < NC; c++) begin
        if (hdr_ok[c] && (!slot_full_q[c] || gnt[c])) begin
          slot_full_q[c] <= 1'b1;
          slot_ep_q[c]   <= ep[EW*c +: EW];
          slot_len_q[c]  <= size_w[c];
        end else if (gnt[c]) begin
          slot_full_q[c] <= 1'b0;
        end
      end
      if (gnt_any) begin
        rr_ptr_q <= (gnt_idx == CW'(NC - 1)) ? '0 : gnt_idx + CW'(1);
      end
    end
  end

  // A full FIFO still accepts a grant when its head is popped in the same cycle.
  assign fifo_full = (count_q == (AW+1)'(FIFO_DEPTH));
  assign evt_valid = (count_q != '0);
  assign pop       = evt_valid && evt_ready;
  assign fifo_room = !fifo_full || pop;
  assign push      = gnt_any;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_chan[i] <= '0;
        fifo_dest[i] <= '0;
        fifo_len[i]  <= '0;
      end
    end else begin
      if (push) begin
        fifo_chan[wr_ptr_q] <= gnt_idx;
        fifo_dest[wr_ptr_q] <= slot_ep_q[gnt_idx];
        fifo_len[wr_ptr_q]  <= slot_len_q[gnt_idx];
        wr_ptr_q            <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign evt_chan = evt_valid ? fifo_chan[rd_ptr_q] : '0;
  assign evt_dest = evt_valid ? fifo_dest[rd_ptr_q] : '0;
  assign evt_len  = evt_valid ? fifo_len[rd_ptr_q]  : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_len_q  <= '0;
      err_drop_q <= '0;
    end else begin
      err_len_q  <= (err_clr ? '0 : err_len_q)  | hdr_bad;
      err_drop_q <= (err_clr ? '0 : err_drop_q) | drop_set;
    end
  end

  assign err_len  = err_len_q;
  assign err_drop = err_drop_q;

`ifdef SM_TDM_SEND_MC_STATS_EN
  logic [NUM_CHANNELS-1:0][15:0] pkt_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt_q <= '0;
    end else begin
      for (int unsigned c = 0; c < NC; c++) begin
        if (err_clr) begin
          pkt_cnt_q[c] <= hdr_ok[c] ? 16'd1 : 16'd0;
        end else if (hdr_ok[c] && pkt_cnt_q[c] != '1) begin
          pkt_cnt_q[c] <= pkt_cnt_q[c] + 16'd1;
        end
      end
    end
  end

  assign pkt_cnt = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_sm_tdm_send_mc.sv
// Directed self-checking bench for sm_tdm_send_mc (default parameters).
module tb_sm_tdm_send_mc;

  logic         clk;
  logic         rst_n;
  logic [3:0]   enable;
  logic [127:0] data;
  logic [7:0]   ep;
  logic         evt_valid;
  logic         evt_ready;
  logic [1:0]   evt_chan;
  logic [1:0]   evt_dest;
  logic [3:0]   evt_len;
  logic [3:0]   err_len;
  logic [3:0]   err_drop;
  logic         err_clr;
`ifdef SM_TDM_SEND_MC_STATS_EN
  logic [63:0]  pkt_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  int n_ev;

  sm_tdm_send_mc #(
    .NUM_CHANNELS      (4),
    .MAX_LEN           (8),
    .NUM_TDM_ENDPOINTS (4),
    .FIFO_DEPTH        (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .data      (data),
    .ep        (ep),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_chan  (evt_chan),
    .evt_dest  (evt_dest),
    .evt_len   (evt_len),
    .err_len   (err_len),
    .err_drop  (err_drop),
    .err_clr   (err_clr)
`ifdef SM_TDM_SEND_MC_STATS_EN
    ,
    .pkt_cnt   (pkt_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_flit(input int c, input logic [31:0] v, input logic [1:0] e);
    enable[c]       = 1'b1;
    data[32*c +: 32] = v;
    ep[2*c +: 2]     = e;
  endtask

  task automatic send(input int c, input logic [31:0] v, input logic [1:0] e);
    enable = '0;
    set_flit(c, v, e);
    tick();
    enable = '0;
  endtask

  task automatic chk_evt(input string tag, input logic [1:0] c, input logic [1:0] d, input logic [3:0] l);
    chk({tag, "_valid"}, 32'(evt_valid), 32'd1);
    chk({tag, "_chan"},  32'(evt_chan),  32'(c));
    chk({tag, "_dest"},  32'(evt_dest),  32'(d));
    chk({tag, "_len"},   32'(evt_len),   32'(l));
  endtask

  initial begin
    rst_n     = 1'b0;
    enable    = '0;
    data      = '0;
    ep        = '0;
    evt_ready = 1'b1;
    err_clr   = 1'b0;
    #12;
    chk("rst_valid",    32'(evt_valid), 32'd0);
    chk("rst_chan",     32'(evt_chan),  32'd0);
    chk("rst_len",      32'(evt_len),   32'd0);
    chk("rst_err_len",  32'(err_len),   32'd0);
    chk("rst_err_drop", 32'(err_drop),  32'd0);
    rst_n = 1'b1;
    tick();

    // Headers on all channels at once; drain masks follow lengths 1..4.
    for (int c = 0; c < 4; c++) set_flit(c, 32'(c + 1), 2'(3 - c));
    tick();
    chk("all_t1_valid", 32'(evt_valid), 32'd0);
    enable = 4'hF; data = '0;
    tick();
    chk_evt("all_c0", 2'd0, 2'd3, 4'd1);
    enable = 4'hE;
    tick();
    chk_evt("all_c1", 2'd1, 2'd2, 4'd2);
    enable = 4'hC;
    tick();
    chk_evt("all_c2", 2'd2, 2'd1, 4'd3);
    enable = 4'h8;
    tick();
    chk_evt("all_c3", 2'd3, 2'd0, 4'd4);
    enable = '0;
    tick();
    chk("all_done_valid", 32'(evt_valid), 32'd0);
    chk("all_err_len",    32'(err_len),   32'd0);

    // Channel 0: header 3 ep 2, three payload flits, then a new header.
    send(0, 32'd3, 2'd2);
    chk("c0_t1_valid", 32'(evt_valid), 32'd0);
    send(0, 32'd0, 2'd0);
    chk_evt("c0_t2", 2'd0, 2'd2, 4'd3);
    send(0, 32'd0, 2'd0);
    chk("c0_t3_valid", 32'(evt_valid), 32'd0);
    send(0, 32'd0, 2'd0);
    send(0, 32'h1230_0005, 2'd1);
    tick();
    chk_evt("c0_next", 2'd0, 2'd1, 4'd5);
    for (int k = 0; k < 5; k++) send(0, 32'd0, 2'd0);
    chk("c0_err_len", 32'(err_len), 32'd0);

    // Channel 1: illegal sizes 0 and 9, legal header 2 with junk upper bits.
    send(1, 32'd0, 2'd0);
    chk("len0_err", 32'(err_len),   32'h2);
    chk("len0_evt", 32'(evt_valid), 32'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("len0_clr", 32'(err_len), 32'd0);
    send(1, 32'h0000_0019, 2'd0);
    chk("len9_err", 32'(err_len), 32'h2);
    tick();
    chk("len9_evt", 32'(evt_valid), 32'd0);
    send(1, 32'hFFFF_FFF2, 2'd1);
    chk("c1_t1_valid", 32'(evt_valid), 32'd0);
    send(1, 32'd0, 2'd0);
    chk_evt("c1_t2", 2'd1, 2'd1, 4'd2);
    send(1, 32'd0, 2'd0);
    chk("c1_err_len", 32'(err_len), 32'h2);
    err_clr = 1'b1;
    send(1, 32'd0, 2'd0);
    err_clr = 1'b0;
    chk("set_wins_clr", 32'(err_len), 32'h2);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_after", 32'(err_len), 32'd0);

    // Channel 2: six single-flit packets with the consumer stalled.
    evt_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      send(2, 32'd1, 2'(k));
      send(2, 32'd0, 2'd0);
    end
    chk("drop_flag",  32'(err_drop),  32'h4);
    chk("drop_valid", 32'(evt_valid), 32'd1);
    evt_ready = 1'b1;
    n_ev = 0;
    for (int i = 0; i < 16; i++) begin
      if (evt_valid) begin
        chk("drain_dest", 32'(evt_dest), 32'(n_ev % 4));
        chk("drain_len",  32'(evt_len),  32'd1);
        chk("drain_chan", 32'(evt_chan), 32'd2);
        n_ev++;
      end
      tick();
    end
    chk("drain_count",  n_ev,           32'd5);
    chk("drop_sticky",  32'(err_drop),  32'h4);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("drop_clr", 32'(err_drop), 32'd0);

    // Asynchronous reset in the middle of a len-5 packet on channel 3.
    evt_ready = 1'b0;
    send(0, 32'd0, 2'd0);
    send(3, 32'd5, 2'd1);
    send(3, 32'd0, 2'd0);
    send(3, 32'd0, 2'd0);
    chk_evt("pre_rst", 2'd3, 2'd1, 4'd5);
    chk("pre_rst_err", 32'(err_len), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid",    32'(evt_valid), 32'd0);
    chk("arst_chan",     32'(evt_chan),  32'd0);
    chk("arst_dest",     32'(evt_dest),  32'd0);
    chk("arst_len",      32'(evt_len),   32'd0);
    chk("arst_err_len",  32'(err_len),   32'd0);
    chk("arst_err_drop", 32'(err_drop),  32'd0);
    #1 rst_n = 1'b1;
    evt_ready = 1'b1;
    tick();
    send(3, 32'd4, 2'd2);
    tick();
    chk_evt("post_rst", 2'd3, 2'd2, 4'd4);
    for (int k = 0; k < 4; k++) send(3, 32'd0, 2'd0);
    chk("post_rst_err", 32'(err_len), 32'd0);

`ifdef SM_TDM_SEND_MC_STATS_EN
    for (int k = 0; k < 3; k++) begin
      send(0, 32'd1, 2'd0);
      send(0, 32'd0, 2'd0);
    end
    send(0, 32'd0, 2'd0);
    chk("stats_cnt3", 32'(pkt_cnt[15:0]), 32'd3);
    #1 force dut.pkt_cnt_q = {4{16'hFFFF}};
    #1 release dut.pkt_cnt_q;
    send(0, 32'd1, 2'd0);
    chk("stats_sat", 32'(pkt_cnt[15:0]), 32'h0000_FFFF);
    send(0, 32'd0, 2'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("stats_clr", 32'(pkt_cnt[15:0]), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
